// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock FWFT FIFO with occupancy count, almost thresholds, sticky errors and flush
module spi_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              FLUSH,
  input  logic              ERR_CLR,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [CW-1:0]     COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_EMPTY,
  output logic              ALMOST_FULL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [CW-1:0] cnt_n;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    push = WR_EN & (~FULL | RD_EN);
    pop = RD_EN & ~EMPTY;
    cnt_n = COUNT + CW'(push) - CW'(pop);
    RD_DATA = mem[rd_ptr];
  end
  always_ff @(posedge PCLK) begin
    if (PRESETn && !FLUSH && push) mem[wr_ptr] <= WR_DATA;
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn || FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      ALMOST_FULL <= 1'b0;
      OVERFLOW <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      COUNT <= cnt_n;
      EMPTY <= cnt_n == '0;
      FULL <= cnt_n == CW'(DEPTH);
      ALMOST_EMPTY <= cnt_n <= CW'(AE_THRESH);
      ALMOST_FULL <= cnt_n >= CW'(AF_THRESH);
      OVERFLOW <= (WR_EN & FULL & ~RD_EN) | (OVERFLOW & ~ERR_CLR);
      UNDERFLOW <= (RD_EN & EMPTY) | (UNDERFLOW & ~ERR_CLR);
    end
  end
endmodule
